// File: rtl/jpeg_idct_pixbuf_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_idct_pixbuf_pkg
// Shared constants and types for the iDCT pixel buffer.
//   IN_W_DEF / OUT_W_DEF : default sample / pixel widths
//   LEVEL_SHIFT          : JPEG level shift added to every iDCT sample
//   PIX_MAX              : upper clamp value of an output pixel
//   rd_state_t           : read-side FSM states
// -----------------------------------------------------------------------------
package jpeg_idct_pixbuf_pkg;

   localparam int unsigned IN_W_DEF    = 9;
   localparam int unsigned OUT_W_DEF   = 8;
   localparam int unsigned LEVEL_SHIFT = 128;
   localparam int unsigned PIX_MAX     = 255;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_LOAD = 2'd1,
      RD_RUN  = 2'd2
   } rd_state_t;

endpackage

// File: rtl/jpeg_idct_pixbuf_ram.sv
// -----------------------------------------------------------------------------
// jpeg_pixbuf_ram
// 128x8 buffer holding both ping-pong banks (address MSB = bank). Stored as
// two 64-entry halves: columns 0..3 written by port 0, columns 4..7 by port 1,
// so both samples of a pair are written in one cycle. One registered read port.
//   i_clk               : clock
//   i_we0/i_waddr0/i_wdata0 : write port, columns 0..3 ({bank,row,col[1:0]})
//   i_we1/i_waddr1/i_wdata1 : write port, columns 4..7 ({bank,row,col[1:0]})
//   i_raddr             : read address {bank,row,col}
//   o_rdata             : read data, valid the cycle after i_raddr
// -----------------------------------------------------------------------------
module jpeg_pixbuf_ram
   import jpeg_idct_pixbuf_pkg::*;
#(
   parameter int unsigned DATA_W = OUT_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_we0,
   input  logic [5:0]        i_waddr0,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic              i_we1,
   input  logic [5:0]        i_waddr1,
   input  logic [DATA_W-1:0] i_wdata1,
   input  logic [6:0]        i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem_lo [64];
   logic [DATA_W-1:0] r_mem_hi [64];
   logic [DATA_W-1:0] r_rdata;
   logic [5:0]        w_rsub;

   // Column bit 2 selects the half; remaining bits index within it.
   assign w_rsub = {i_raddr[6:3], i_raddr[1:0]};

   always_ff @(posedge i_clk) begin
      if (i_we0) r_mem_lo[i_waddr0] <= i_wdata0;
      if (i_we1) r_mem_hi[i_waddr1] <= i_wdata1;
      r_rdata <= i_raddr[2] ? r_mem_hi[w_rsub] : r_mem_lo[w_rsub];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/jpeg_idct_pixbuf.sv
// -----------------------------------------------------------------------------
// jpeg_idct_pixbuf
// Level-shifts and clamps the 8x8 iDCT result stream, stores each block in a
// two-bank ping-pong buffer and replays it in raster order over valid/ready.
//   clk, rst                 : clock, asynchronous active-high reset
//   ProcessInit              : synchronous clear of all buffer state
//   DataInEnable/Page/Count  : sample pair strobe and position
//   Data0In / Data1In        : samples for column Count / 7-Count
//   DataInIdle               : a free bank can take a new block
//   Overflow                 : sticky, write arrived with no free bank
//   PixelValid/Ready/Data    : pixel output handshake and value
//   PixelX / PixelY          : column / row of the presented pixel
//   PixelLast                : presented pixel is (7,7)
// -----------------------------------------------------------------------------
module jpeg_idct_pixbuf
   import jpeg_idct_pixbuf_pkg::*;
#(
   parameter int unsigned IN_W  = IN_W_DEF,
   parameter int unsigned OUT_W = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ProcessInit,
   input  logic             DataInEnable,
   input  logic [2:0]       DataInPage,
   input  logic [1:0]       DataInCount,
   input  logic [IN_W-1:0]  Data0In,
   input  logic [IN_W-1:0]  Data1In,
   output logic             DataInIdle,
   output logic             Overflow,
   output logic             PixelValid,
   input  logic             PixelReady,
   output logic [OUT_W-1:0] PixelData,
   output logic [2:0]       PixelX,
   output logic [2:0]       PixelY,
   output logic             PixelLast
);

   localparam logic signed [IN_W:0] C_SHIFT   = (IN_W+1)'(LEVEL_SHIFT);
   localparam logic signed [IN_W:0] C_PIX_MAX = (IN_W+1)'(PIX_MAX);

   rd_state_t         r_state, w_state_nxt;
   logic [1:0]        r_full, w_full_nxt;
   logic              r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt;
   logic [5:0]        r_cnt, w_cnt_inc, w_rd_pix;
   logic              r_idle, r_ovf;
   logic              w_wr_full, w_wr_en, w_complete, w_xfer, w_release, w_valid;
   logic signed [IN_W:0] w_v0, w_v1;
   logic [OUT_W-1:0]  w_pix0, w_pix1, w_rdata;

   // Level shift in IN_W+1 bits, then clamp to 0..PIX_MAX.
   always_comb begin
      w_v0 = $signed({Data0In[IN_W-1], Data0In}) + C_SHIFT;
      w_v1 = $signed({Data1In[IN_W-1], Data1In}) + C_SHIFT;
      if (w_v0[IN_W])             w_pix0 = '0;
      else if (w_v0 > C_PIX_MAX)  w_pix0 = OUT_W'(PIX_MAX);
      else                        w_pix0 = w_v0[OUT_W-1:0];
      if (w_v1[IN_W])             w_pix1 = '0;
      else if (w_v1 > C_PIX_MAX)  w_pix1 = OUT_W'(PIX_MAX);
      else                        w_pix1 = w_v1[OUT_W-1:0];
   end

   assign w_wr_full  = r_full[r_wr_ptr];
   assign w_wr_en    = DataInEnable & ~w_wr_full & ~ProcessInit;
   assign w_complete = w_wr_en & (DataInPage == 3'd7) & (DataInCount == 2'd3);
   assign w_cnt_inc  = r_cnt + 6'd1;

   // Read FSM next state / outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_valid     = 1'b0;
      w_xfer      = 1'b0;
      w_release   = 1'b0;
      unique case (r_state)
         RD_IDLE: if (r_full[r_rd_ptr]) w_state_nxt = RD_LOAD;
         RD_LOAD: w_state_nxt = RD_RUN;
         RD_RUN: begin
            w_valid = 1'b1;
            if (PixelReady) begin
               w_xfer = 1'b1;
               if (r_cnt == 6'd63) begin
                  w_release   = 1'b1;
                  w_state_nxt = RD_IDLE;
               end
            end
         end
         default: w_state_nxt = RD_IDLE;
      endcase
   end

   // Bank flags: completion and release always target different banks.
   always_comb begin
      w_full_nxt = r_full;
      if (w_complete) w_full_nxt[r_wr_ptr] = 1'b1;
      if (w_release)  w_full_nxt[r_rd_ptr] = 1'b0;
      w_wr_ptr_nxt = r_wr_ptr ^ w_complete;
   end

   // Prefetch: on a transfer fetch the next pixel, otherwise re-read the
   // current one so the registered RAM output stays stable while stalled.
   assign w_rd_pix = w_xfer ? w_cnt_inc : r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RD_IDLE;
      end else if (ProcessInit) begin
         r_state <= RD_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full   <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= '0;
         r_idle   <= 1'b1;
         r_ovf    <= 1'b0;
      end else if (ProcessInit) begin
         r_full   <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= '0;
         r_idle   <= 1'b1;
         r_ovf    <= 1'b0;
      end else begin
         r_full   <= w_full_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= r_rd_ptr ^ w_release;
         if (w_xfer) r_cnt <= w_cnt_inc;
         r_idle   <= ~w_full_nxt[w_wr_ptr_nxt];
         if (DataInEnable & w_wr_full) r_ovf <= 1'b1;
      end
   end

   jpeg_pixbuf_ram #(
      .DATA_W (OUT_W)
   ) u_ram (
      .i_clk    (clk),
      .i_we0    (w_wr_en),
      .i_waddr0 ({r_wr_ptr, DataInPage, DataInCount}),
      .i_wdata0 (w_pix0),
      .i_we1    (w_wr_en),
      .i_waddr1 ({r_wr_ptr, DataInPage, ~DataInCount}),
      .i_wdata1 (w_pix1),
      .i_raddr  ({r_rd_ptr, w_rd_pix}),
      .o_rdata  (w_rdata)
   );

   assign DataInIdle = r_idle;
   assign Overflow   = r_ovf;
   assign PixelValid = w_valid;
   assign PixelData  = w_valid ? w_rdata : '0;
   assign PixelX     = r_cnt[2:0];
   assign PixelY     = r_cnt[5:3];
   assign PixelLast  = w_valid & (r_cnt == 6'd63);

endmodule

// File: tb/tb_jpeg_idct_pixbuf.sv
// -----------------------------------------------------------------------------
// tb_jpeg_idct_pixbuf
// Self-checking bench for jpeg_idct_pixbuf: expected pixels are pushed to a
// queue when a block is written and compared as the DUT transfers them.
// -----------------------------------------------------------------------------
module tb_jpeg_idct_pixbuf;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ProcessInit = 1'b0;
   logic       DataInEnable = 1'b0;
   logic [2:0] DataInPage = '0;
   logic [1:0] DataInCount = '0;
   logic [8:0] Data0In = '0;
   logic [8:0] Data1In = '0;
   logic       DataInIdle, Overflow, PixelValid, PixelLast;
   logic       PixelReady = 1'b0;
   logic [7:0] PixelData;
   logic [2:0] PixelX, PixelY;

   jpeg_idct_pixbuf #(
      .IN_W  (9),
      .OUT_W (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ProcessInit  (ProcessInit),
      .DataInEnable (DataInEnable),
      .DataInPage   (DataInPage),
      .DataInCount  (DataInCount),
      .Data0In      (Data0In),
      .Data1In      (Data1In),
      .DataInIdle   (DataInIdle),
      .Overflow     (Overflow),
      .PixelValid   (PixelValid),
      .PixelReady   (PixelReady),
      .PixelData    (PixelData),
      .PixelX       (PixelX),
      .PixelY       (PixelY),
      .PixelLast    (PixelLast)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]        sb[$];
   logic [5:0]        exp_idx = '0;
   logic signed [8:0] samp [64];

   bit throttle_en = 1'b0;
   bit ready_force = 1'b0;

   always @(posedge clk) begin
      #1;
      PixelReady = throttle_en ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // Output monitor / scoreboard
   bit         prev_stall = 1'b0;
   logic [7:0] h_data;
   logic [2:0] h_x, h_y;
   logic       h_last;
   bit         in_gap = 1'b0;
   int         gap = 0;
   bit         gap_chk_en = 1'b0;
   logic [7:0] exp_pix;

   always @(negedge clk) begin
      if (!rst) begin
         if (in_gap) begin
            if (!PixelValid) gap++;
            else begin
               in_gap = 1'b0;
               if (gap_chk_en) begin
                  checks++;
                  if (gap !== 2) begin
                     errors++;
                     $display("FAIL block_gap got %0d cycles expected 2", gap);
                  end
               end
            end
         end
         if (PixelValid) begin
            if (prev_stall) begin
               checks++;
               if ({PixelData, PixelX, PixelY, PixelLast} !== {h_data, h_x, h_y, h_last}) begin
                  errors++;
                  $display("FAIL stall_hold got d=%0d x=%0d y=%0d l=%0b expected d=%0d x=%0d y=%0d l=%0b",
                           PixelData, PixelX, PixelY, PixelLast, h_data, h_x, h_y, h_last);
               end
            end
            if (PixelReady) begin
               prev_stall = 1'b0;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_pixel got d=%0d x=%0d y=%0d expected none", PixelData, PixelX, PixelY);
               end else begin
                  exp_pix = sb.pop_front();
                  if (PixelData !== exp_pix || PixelX !== exp_idx[2:0] || PixelY !== exp_idx[5:3] ||
                      PixelLast !== (exp_idx == 6'd63)) begin
                     errors++;
                     $display("FAIL pixel got d=%0d x=%0d y=%0d l=%0b expected d=%0d x=%0d y=%0d l=%0b",
                              PixelData, PixelX, PixelY, PixelLast, exp_pix, exp_idx[2:0], exp_idx[5:3],
                              (exp_idx == 6'd63));
                  end
                  if (exp_idx == 6'd63) begin
                     in_gap = 1'b1;
                     gap    = 0;
                  end
                  exp_idx = exp_idx + 6'd1;
               end
            end else begin
               prev_stall = 1'b1;
               h_data = PixelData;
               h_x    = PixelX;
               h_y    = PixelY;
               h_last = PixelLast;
            end
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   function automatic logic [7:0] model_pix(input logic signed [8:0] s);
      int v;
      v = int'(s) + 128;
      if (v < 0)   return 8'd0;
      if (v > 255) return 8'd255;
      return v[7:0];
   endfunction

   task automatic flush_sb();
      sb.delete();
      exp_idx    = '0;
      prev_stall = 1'b0;
      in_gap     = 1'b0;
   endtask

   task automatic fill_zero();
      for (int i = 0; i < 64; i++) samp[i] = '0;
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) samp[r*8+c] = 9'(r*16 + c - 128);
   endtask

   task automatic fill_clamp();
      int cv[8] = '{-256, -129, -128, -1, 0, 127, 255, 100};
      for (int i = 0; i < 64; i++) samp[i] = 9'(cv[(i + i/8) % 8]);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 64; i++) samp[i] = 9'($urandom_range(0, 511));
   endtask

   // Column-major pair order so (7,3) arrives last.
   task automatic write_block(input int npairs, input bit push);
      for (int k = 0; k < npairs; k++) begin
         int pg = k % 8;
         int ct = k / 8;
         DataInEnable = 1'b1;
         DataInPage   = 3'(pg);
         DataInCount  = 2'(ct);
         Data0In      = samp[pg*8 + ct];
         Data1In      = samp[pg*8 + 7 - ct];
         @(posedge clk); #1;
      end
      DataInEnable = 1'b0;
      if (push) for (int i = 0; i < 64; i++) sb.push_back(model_pix(samp[i]));
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || PixelValid) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0 || PixelValid) begin
         errors++;
         $display("FAIL drain_timeout got %0d pixels pending valid=%0b expected 0 pending", sb.size(), PixelValid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({DataInIdle, Overflow, PixelValid, PixelData, PixelX, PixelY, PixelLast} !== {1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_held got idle=%0b ovf=%0b v=%0b d=%0d x=%0d y=%0d l=%0b expected idle=1 rest 0",
                  DataInIdle, Overflow, PixelValid, PixelData, PixelX, PixelY, PixelLast);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({DataInIdle, Overflow, PixelValid, PixelLast} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_release got idle=%0b ovf=%0b v=%0b l=%0b expected 1000",
                  DataInIdle, Overflow, PixelValid, PixelLast);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_zero();
      ready_force = 1'b1;
      fill_zero();
      write_block(32, 1'b1);
      @(negedge clk);
      checks++;
      if (PixelValid !== 1'b0 || DataInIdle !== 1'b1) begin
         errors++;
         $display("FAIL latency_e0 got v=%0b idle=%0b expected v=0 idle=1", PixelValid, DataInIdle);
      end
      @(negedge clk);
      checks++;
      if (PixelValid !== 1'b0) begin
         errors++;
         $display("FAIL latency_e1 got v=%0b expected 0", PixelValid);
      end
      @(negedge clk);
      checks++;
      if (PixelValid !== 1'b1) begin
         errors++;
         $display("FAIL latency_e2 got v=%0b expected 1", PixelValid);
      end
      @(posedge clk); #1;
      wait_drain(200);
   endtask

   task automatic test_ramp();
      fill_ramp();
      write_block(32, 1'b1);
      wait_drain(200);
   endtask

   task automatic test_clamp();
      fill_clamp();
      write_block(32, 1'b1);
      wait_drain(200);
   endtask

   task automatic test_throttle();
      throttle_en = 1'b1;
      fill_rand();
      write_block(32, 1'b1);
      fill_rand();
      write_block(32, 1'b1);
      wait_drain(1000);
      throttle_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      ready_force = 1'b0;
      @(posedge clk); #1;
      fill_rand();
      write_block(32, 1'b1);
      fill_rand();
      write_block(32, 1'b1);
      @(negedge clk);
      checks++;
      if (DataInIdle !== 1'b0 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL both_full got idle=%0b ovf=%0b expected idle=0 ovf=0", DataInIdle, Overflow);
      end
      @(posedge clk); #1;
      fill_rand();
      write_block(32, 1'b0);
      @(negedge clk);
      checks++;
      if (Overflow !== 1'b1 || DataInIdle !== 1'b0) begin
         errors++;
         $display("FAIL overflow_set got ovf=%0b idle=%0b expected ovf=1 idle=0", Overflow, DataInIdle);
      end
      @(posedge clk); #1;
      gap_chk_en  = 1'b1;
      ready_force = 1'b1;
      wait_drain(400);
      gap_chk_en  = 1'b0;
      checks++;
      if (Overflow !== 1'b1 || DataInIdle !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky got ovf=%0b idle=%0b expected ovf=1 idle=1", Overflow, DataInIdle);
      end
   endtask

   task automatic test_process_init();
      int n = 0;
      ready_force = 1'b0;
      @(posedge clk); #1;
      fill_rand();
      write_block(32, 1'b1);
      fill_rand();
      write_block(32, 1'b1);
      ready_force = 1'b1;
      while (exp_idx != 6'd20 && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      checks++;
      if (exp_idx != 6'd20) begin
         errors++;
         $display("FAIL init_reach_px20 got idx=%0d expected 20", exp_idx);
      end
      // Completion pair in the init cycle must be ignored.
      ProcessInit  = 1'b1;
      DataInEnable = 1'b1;
      DataInPage   = 3'd7;
      DataInCount  = 2'd3;
      @(posedge clk); #1;
      ProcessInit  = 1'b0;
      DataInEnable = 1'b0;
      flush_sb();
      checks++;
      if ({PixelValid, DataInIdle, Overflow} !== 3'b010) begin
         errors++;
         $display("FAIL init_clear got v=%0b idle=%0b ovf=%0b expected v=0 idle=1 ovf=0",
                  PixelValid, DataInIdle, Overflow);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (PixelValid !== 1'b0) begin
         errors++;
         $display("FAIL init_ignored_write got v=%0b expected 0", PixelValid);
      end
      @(posedge clk); #1;
      fill_rand();
      write_block(32, 1'b1);
      wait_drain(200);
   endtask

   task automatic test_async_reset();
      ready_force = 1'b0;
      @(posedge clk); #1;
      fill_rand();
      write_block(32, 1'b1);
      fill_rand();
      write_block(10, 1'b0);
      DataInEnable = 1'b1;
      checks++;
      if (PixelValid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_valid got v=%0b expected 1", PixelValid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({DataInIdle, Overflow, PixelValid, PixelData, PixelX, PixelY, PixelLast} !== {1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got idle=%0b ovf=%0b v=%0b d=%0d x=%0d y=%0d l=%0b expected idle=1 rest 0",
                  DataInIdle, Overflow, PixelValid, PixelData, PixelX, PixelY, PixelLast);
      end
      DataInEnable = 1'b0;
      flush_sb();
      @(posedge clk); #1;
      rst = 1'b0;
      ready_force = 1'b1;
      @(posedge clk); #1;
      fill_ramp();
      write_block(32, 1'b1);
      wait_drain(200);
   endtask

   initial begin
      test_reset();
      test_single_zero();
      test_ramp();
      test_clamp();
      test_throttle();
      test_back_to_back();
      test_process_init();
      test_async_reset();
      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got no finish expected finish before 1ms");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jpeg_idct_pixbuf.md
Name: jpeg_idct_pixbuf

Overview:
- Sits directly downstream of the two-pass iDCT top.
- Consumes its 8x8 result stream: page/count addressed, two 9-bit signed samples per cycle.
- Applies the +128 level shift and clamps each sample to 0..255, then stores the block in a 2-bank ping-pong buffer.
- Replays each block in raster order over a valid/ready pixel interface to the colour-conversion/output stage.

Parameters:
- IN_W, 9, width of signed iDCT samples on Data0In/Data1In.
- OUT_W, 8, width of unsigned pixel output.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- ProcessInit  input  1  synchronous clear of all buffer state at frame start.
- DataInEnable  input  1  sample pair valid this cycle.
- DataInPage  input  3  block row (0..7).
- DataInCount  input  2  column selector (0..3).
- Data0In  input  IN_W  signed sample for column = DataInCount.
- Data1In  input  IN_W  signed sample for column = 7-DataInCount.
- DataInIdle  output  1  high when a free bank exists to accept a new block.
- Overflow  output  1  sticky: a write arrived while no bank was free.
- PixelValid  output  1  pixel on PixelData is valid.
- PixelReady  input  1  downstream accepts the pixel.
- PixelData  output  OUT_W  clamped, level-shifted pixel.
- PixelX  output  3  column of the current pixel.
- PixelY  output  3  row of the current pixel.
- PixelLast  output  1  high with pixel (7,7) of the block.

Behaviour:
- Reset (async, rst=1): all outputs 0 except DataInIdle=1. Both banks empty; write and read pointers at bank 0; read FSM in IDLE; Overflow=0. RAM contents undefined.
- Arithmetic:
  - v = sign-extend(Data) + 128, computed in IN_W+1 bits.
  - pix = 0 if v<0; 255 if v>255; otherwise v[7:0].
  - Examples: -256→0, -129→0, -128→0, -1→127, 0→128, 127→255, 255→255.
- Write side:
  - On DataInEnable with the write bank free: store pix0 at (row=Page, col=Count) and pix1 at (row=Page, col=7-Count).
  - Arrival order is not assumed; only the final pair completes the block.
  - Block completion occurs on the pair Page=7, Count=3. On that edge the write bank is marked full and the write pointer toggles.
  - DataInIdle = (write bank not full), registered.
- Overflow: DataInEnable while the write bank is full drops the data, sets Overflow (sticky until rst/ProcessInit), and leaves state unchanged.
- Read FSM states:
  - IDLE: when the read bank is full, go to LOAD.
  - LOAD: issue RAM read for pixel 0; go to RUN.
  - RUN: PixelValid=1. Transfer occurs when PixelValid & PixelReady; the pixel counter advances 0..63 in raster order (X fastest).
  - In RUN, outputs are held stable while PixelReady=0. The next pixel is presented the cycle after a transfer, with no bubbles inside a block (RAM prefetch).
  - After the transfer of pixel 63 (PixelLast=1): release the read bank (mark empty), toggle the read pointer, return to IDLE.
- Latency:
  - Completion write sampled on edge E → PixelValid=1 after edge E+2 (IDLE→LOAD at E+1, RUN at E+2).
  - Back-to-back blocks: PixelValid is low for exactly 2 cycles between PixelLast transfer and the next block's pixel 0.
- Simultaneous events:
  - A block completing on the same edge its target bank is released by the reader is impossible by construction, since write and read banks differ.
  - The reader releasing bank A on the same edge the writer fills bank B: both take effect.
  - DataInIdle returns to 1 the cycle after release.
- ProcessInit: on the edge it is sampled, all flags, pointers, counters, FSM and Overflow clear to reset values. PixelValid=0 the next cycle. Input data in the same cycle is ignored. Takes priority over all other events.

Decomposition:
- Shared package holds:
  - IN_W/OUT_W defaults.
  - LEVEL_SHIFT=128, PIX_MAX=255.
  - Read FSM state encoding (IDLE, LOAD, RUN).
- One natural sub-module: jpeg_pixbuf_ram, a 128x8 dual-port RAM (two write ports or a split 64-entry pair per column half, one read port) used for both banks; bank select is the address MSB.
- Clamp logic stays inline.

Test Plan:
- Single block, all samples 0, PixelReady=1 → 64 pixels of 128; PixelValid rises at edge E+2; PixelLast only on X=7, Y=7.
- Ramp block, Data0In=Page*16+Count-128 → pixel values verify position mapping (col Count and 7-Count); clamp cases -256→0, 255→255, -1→127.
- Random PixelReady throttling (~50%) → data and X/Y held stable while stalled; all 64 pixels delivered in raster order exactly once.
- PixelReady=0 while two blocks are written → DataInIdle=0 after the second completes; a third block's writes set Overflow=1; release ready → blocks 1 and 2 are output intact, with a 2-cycle gap between them.
- ProcessInit asserted mid-output (pixel 20) with the other bank full → PixelValid=0 next cycle, DataInIdle=1, Overflow=0; a new block then outputs normally from pixel 0.
- rst asserted asynchronously mid-write → outputs go to reset values immediately; the next full block is processed correctly.
